// File: rtl/avalon_sample_writer.sv
// Avalon-MM write master that drains a valid/ready sample stream through a small FIFO
// into a circular word window, one write per accepted sample.
module avalon_sample_writer #(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned       DEPTH_WORDS = 1024,
    parameter int unsigned       FIFO_DEPTH  = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           clear,
    input  logic                           in_valid,
    input  logic [DATA_W-1:0]              in_data,
    output logic                           in_ready,
    output logic [ADDR_W-1:0]              master_address,
    output logic                           master_write,
    output logic [DATA_W-1:0]              master_writedata,
    output logic [DATA_W/8-1:0]            master_byteenable,
    input  logic                           master_waitrequest,
    output logic [$clog2(DEPTH_WORDS)-1:0] wr_index,
    output logic                           wrap,
    output logic [31:0]                    words_written
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        S_IDLE,
        S_WRITE
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  fifo_cnt_q;
    logic [CNT_W-1:0]  fifo_cnt_d;
    logic [IDX_W-1:0]  cur_idx_q;
    logic [IDX_W-1:0]  idx_d;
    logic [31:0]       words_d;
    logic              stale_q;
    logic              stale_d;
    logic              wrap_d;
    logic              push_c;
    logic              pop_c;
    logic              accept_c;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, FIFO handshakes and write bookkeeping
    always_comb begin
        state_d    = state_q;
        pop_c      = 1'b0;
        push_c     = in_valid && in_ready;
        accept_c   = (state_q == S_WRITE) && !master_waitrequest;
        idx_d      = wr_index;
        words_d    = words_written;
        stale_d    = stale_q;
        wrap_d     = accept_c && (cur_idx_q == LAST_IDX);
        fifo_cnt_d = fifo_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (enable && (fifo_cnt_q != '0)) begin
                    pop_c   = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (accept_c) begin
                    if (enable && (fifo_cnt_q != '0)) begin
                        pop_c = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A write issued before a clear lands at its old address but is not counted
        if (clear) begin
            idx_d   = '0;
            words_d = '0;
        end else if (accept_c && !stale_q) begin
            idx_d = wr_index + IDX_W'(1);
            if (words_written != '1) begin
                words_d = words_written + 32'd1;
            end
        end

        if (accept_c) begin
            stale_d = 1'b0;
        end else if (clear && (state_q == S_WRITE)) begin
            stale_d = 1'b1;
        end

        fifo_cnt_d = fifo_cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    // FIFO storage, no reset needed on the data array
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem[wr_ptr_q] <= in_data;
        end
    end

    // Registered datapath and outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q          <= '0;
            wr_ptr_q          <= '0;
            fifo_cnt_q        <= '0;
            in_ready          <= 1'b0;
            master_write      <= 1'b0;
            master_byteenable <= '0;
            master_address    <= BASE_ADDR;
            master_writedata  <= '0;
            cur_idx_q         <= '0;
            wr_index          <= '0;
            words_written     <= '0;
            wrap              <= 1'b0;
            stale_q           <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q         <= rd_ptr_q + PTR_W'(1);
                master_writedata <= fifo_mem[rd_ptr_q];
                master_address   <= BASE_ADDR + (ADDR_W'(idx_d) << 2);
                cur_idx_q        <= idx_d;
            end
            fifo_cnt_q        <= fifo_cnt_d;
            in_ready          <= (fifo_cnt_d != FULL_CNT);
            master_write      <= (state_d == S_WRITE);
            master_byteenable <= {(DATA_W/8){state_d == S_WRITE}};
            wr_index          <= idx_d;
            words_written     <= words_d;
            wrap              <= wrap_d;
            stale_q           <= stale_d;
        end
    end

endmodule

// File: tb/tb_avalon_sample_writer.sv
// Bench for avalon_sample_writer: transaction-level model of the sample log checked every
// cycle, plus directed scenarios with hand-computed expectations and a randomized run.
module tb_avalon_sample_writer;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned FD     = 8;
    localparam logic [31:0] BASE   = 32'h0000_1000;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     enable = 1'b0;
    logic                     clear = 1'b0;
    logic                     in_valid = 1'b0;
    logic [DATA_W-1:0]        in_data = '0;
    logic                     in_ready;
    logic [ADDR_W-1:0]        master_address;
    logic                     master_write;
    logic [DATA_W-1:0]        master_writedata;
    logic [DATA_W/8-1:0]      master_byteenable;
    logic                     master_waitrequest = 1'b0;
    logic [$clog2(DEPTH)-1:0] wr_index;
    logic                     wrap;
    logic [31:0]              words_written;

    avalon_sample_writer #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .clear              (clear),
        .in_valid           (in_valid),
        .in_data            (in_data),
        .in_ready           (in_ready),
        .master_address     (master_address),
        .master_write       (master_write),
        .master_writedata   (master_writedata),
        .master_byteenable  (master_byteenable),
        .master_waitrequest (master_waitrequest),
        .wr_index           (wr_index),
        .wrap               (wrap),
        .words_written      (words_written)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: samples queued but not yet issued, plus the one write in flight
    logic [31:0] q[$];
    bit          m_mw = 1'b0;
    bit          m_ir = 1'b0;
    bit          m_wrap = 1'b0;
    int          nidx = 0;
    logic [31:0] nwords = '0;
    logic [31:0] pend_data = '0;
    int          pend_idx = 0;
    bit          pend_counts = 1'b0;

    // Acceptance log taken from the bus itself
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    int          log_cyc[$];
    int          cyc = 0;
    int          acc_cnt = 0;
    int          wrap_cnt = 0;
    int          wrap_at = 0;

    // Inputs change only at posedge+1, so the negedge sees what the next edge will see
    always @(negedge clk) begin
        bit acc;
        bit issue;
        cyc++;
        if (reset) begin
            check("rst_write", 32'(master_write), 32'd0);
            check("rst_address", master_address, BASE);
            check("rst_writedata", master_writedata, 32'd0);
            check("rst_wr_index", 32'(wr_index), 32'd0);
            check("rst_wrap", 32'(wrap), 32'd0);
            check("rst_words", words_written, 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd0);
            q.delete();
            m_mw = 1'b0;
            m_ir = 1'b0;
            m_wrap = 1'b0;
            nidx = 0;
            nwords = '0;
            pend_counts = 1'b0;
        end else begin
            check("master_write", 32'(master_write), 32'(m_mw));
            if (m_mw) begin
                check("address", master_address, BASE + 32'(pend_idx * 4));
                check("writedata", master_writedata, pend_data);
                check("byteenable", 32'(master_byteenable), 32'hF);
            end
            check("wr_index", 32'(wr_index), 32'(nidx));
            check("words_written", words_written, nwords);
            check("wrap", 32'(wrap), 32'(m_wrap));
            check("in_ready", 32'(in_ready), 32'(m_ir));

            if (wrap) begin
                wrap_cnt++;
                wrap_at = acc_cnt;
            end
            if (master_write && !master_waitrequest) begin
                log_addr.push_back(master_address);
                log_data.push_back(master_writedata);
                log_cyc.push_back(cyc);
                acc_cnt++;
            end

            acc = m_mw && !master_waitrequest;
            m_wrap = acc && (pend_idx == int'(DEPTH) - 1);
            if (clear) begin
                nidx = 0;
                nwords = '0;
                if (m_mw && !acc) pend_counts = 1'b0;
            end else if (acc && pend_counts) begin
                nidx = (nidx + 1) % int'(DEPTH);
                if (nwords != 32'hFFFF_FFFF) nwords = nwords + 32'd1;
            end
            issue = (!m_mw || acc) && enable && (q.size() > 0);
            if (issue) begin
                pend_data = q.pop_front();
                pend_idx = nidx;
                pend_counts = 1'b1;
            end
            m_mw = (m_mw && !acc) || issue;
            if (in_valid && m_ir) q.push_back(in_data);
            m_ir = (q.size() < int'(FD));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
        acc_cnt = 0;
        wrap_cnt = 0;
        wrap_at = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        clear = 1'b0;
        in_valid = 1'b0;
        master_waitrequest = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        clear_log();
    endtask

    task automatic push_word(input logic [31:0] d);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data = d;
        while (!in_ready && t < 200) begin
            tick();
            t++;
        end
        if (!in_ready) begin
            errors++;
            checks++;
            $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles", t);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (q.size() == 0 && !m_mw) return;
        end
        errors++;
        checks++;
        $display("FAIL drain_timeout: writes pending after %0d cycles", budget);
    endtask

    initial begin
        int n;

        // Latency: empty FIFO push to master_write is two edges
        do_reset();
        enable = 1'b1;
        push_word(32'h1234_5678);
        check("lat_write_after_1", 32'(master_write), 32'd0);
        tick();
        check("lat_write_after_2", 32'(master_write), 32'd1);
        check("lat_address", master_address, BASE);
        check("lat_data", master_writedata, 32'h1234_5678);
        drain(20);

        // Four back-to-back writes
        do_reset();
        for (int i = 0; i < 4; i++) push_word(32'hA5A5_0001 + 32'(i));
        enable = 1'b1;
        drain(50);
        check("b2b_count", 32'(log_addr.size()), 32'd4);
        if (log_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("b2b_addr", log_addr[i], BASE + 32'(4 * i));
                check("b2b_data", log_data[i], 32'hA5A5_0001 + 32'(i));
                check("b2b_cycle", 32'(log_cyc[i]), 32'(log_cyc[0] + i));
            end
        end
        check("b2b_words", words_written, 32'd4);
        check("b2b_index", 32'(wr_index), 32'd4);

        // Fill to full, then stall the first write for five cycles
        do_reset();
        n = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!in_ready) break;
            in_data = 32'hB000_0000 + 32'(i);
            tick();
            n++;
        end
        in_valid = 1'b0;
        check("fill_count", 32'(n), 32'(FD));
        check("full_in_ready", 32'(in_ready), 32'd0);
        master_waitrequest = 1'b1;
        enable = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_write", 32'(master_write), 32'd1);
            check("stall_address", master_address, BASE);
            check("stall_data", master_writedata, 32'hB000_0000);
            tick();
        end
        check("stall_no_accept", 32'(acc_cnt), 32'd0);
        master_waitrequest = 1'b0;
        tick();
        master_waitrequest = 1'b1;
        repeat (2) tick();
        check("stall_one_accept", 32'(acc_cnt), 32'd1);
        master_waitrequest = 1'b0;
        drain(50);
        check("stall_total", 32'(acc_cnt), 32'(FD));

        // Ten writes around an eight-word window
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 10; i++) push_word(32'hC000_0000 + 32'(i));
        drain(50);
        check("wrap_count", 32'(wrap_cnt), 32'd1);
        check("wrap_on_8th", 32'(wrap_at), 32'd8);
        if (log_addr.size() == 10) begin
            check("wrap_addr8", log_addr[8], BASE);
            check("wrap_addr9", log_addr[9], BASE + 32'd4);
        end
        check("wrap_words", words_written, 32'd10);
        check("wrap_index", 32'(wr_index), 32'd2);

        // enable dropped during a stalled write
        do_reset();
        enable = 1'b1;
        master_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) push_word(32'hD000_0000 + 32'(i));
        repeat (2) tick();
        enable = 1'b0;
        repeat (2) tick();
        master_waitrequest = 1'b0;
        repeat (4) tick();
        check("pause_accepts", 32'(acc_cnt), 32'd1);
        check("pause_write", 32'(master_write), 32'd0);
        check("pause_words", words_written, 32'd1);
        enable = 1'b1;
        drain(50);
        check("resume_accepts", 32'(acc_cnt), 32'd3);
        if (log_data.size() == 3) begin
            check("resume_data1", log_data[1], 32'hD000_0001);
            check("resume_data2", log_data[2], 32'hD000_0002);
        end

        // clear while a write to index 7 is stalled
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 7; i++) push_word(32'hE000_0000 + 32'(i));
        drain(50);
        check("clr_pre_index", 32'(wr_index), 32'd7);
        master_waitrequest = 1'b1;
        push_word(32'hE100_0000);
        push_word(32'hE100_0001);
        tick();
        check("clr_pending_addr", master_address, BASE + 32'h1C);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_words_zero", words_written, 32'd0);
        check("clr_index_zero", 32'(wr_index), 32'd0);
        tick();
        master_waitrequest = 1'b0;
        drain(50);
        if (log_addr.size() == 9) begin
            check("clr_old_addr", log_addr[7], BASE + 32'h1C);
            check("clr_new_addr", log_addr[8], BASE);
            check("clr_new_data", log_data[8], 32'hE100_0001);
        end else begin
            check("clr_log_size", 32'(log_addr.size()), 32'd9);
        end
        check("clr_words_after", words_written, 32'd1);
        check("clr_index_after", 32'(wr_index), 32'd1);
        check("clr_wrap", 32'(wrap_cnt), 32'd1);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            tick();
            in_valid = ($urandom_range(0, 2) != 0);
            in_data = $urandom;
            enable = ($urandom_range(0, 7) != 0);
            master_waitrequest = ($urandom_range(0, 2) == 0);
            clear = ($urandom_range(0, 39) == 0);
        end
        clear = 1'b0;
        in_valid = 1'b0;
        enable = 1'b1;
        master_waitrequest = 1'b0;
        drain(100);

        // Asynchronous reset in the middle of a stalled burst
        master_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) push_word(32'hF000_0000 + 32'(i));
        check("prerst_write", 32'(master_write), 32'd1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_write", 32'(master_write), 32'd0);
        check("async_rst_address", master_address, BASE);
        check("async_rst_data", master_writedata, 32'd0);
        check("async_rst_words", words_written, 32'd0);
        check("async_rst_index", 32'(wr_index), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd0);
        master_waitrequest = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        check("rel_in_ready_0", 32'(in_ready), 32'd0);
        tick();
        check("rel_in_ready_1", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("rel_fifo_empty", 32'(master_write), 32'd0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
